// File: rtl/computation_sequencer_if.sv
// computation_sequencer_if: command, engine handshake and result bundle
// between the sequencer and its surroundings.
interface computation_sequencer_if;
    logic       start;
    logic [1:0] mode;
    logic       done_store;
    logic       done_single;
    logic       done_sa3;
    logic       done_sa2;
    logic [7:0] c11;
    logic [7:0] c12;
    logic [7:0] c21;
    logic [7:0] c22;
    logic       result_ready;
    logic       active_store;
    logic       active_single;
    logic       active_sa3;
    logic       active_sa2;
    logic       busy;
    logic       result_valid;
    logic [7:0] r11;
    logic [7:0] r12;
    logic [7:0] r21;
    logic [7:0] r22;
    logic       err_mode;
    logic       err_timeout;

    modport master (
        output start, mode,
        output done_store, done_single, done_sa3, done_sa2,
        output c11, c12, c21, c22,
        output result_ready,
        input  active_store, active_single, active_sa3, active_sa2,
        input  busy, result_valid,
        input  r11, r12, r21, r22,
        input  err_mode, err_timeout
    );

    modport slave (
        input  start, mode,
        input  done_store, done_single, done_sa3, done_sa2,
        input  c11, c12, c21, c22,
        input  result_ready,
        output active_store, active_single, active_sa3, active_sa2,
        output busy, result_valid,
        output r11, r12, r21, r22,
        output err_mode, err_timeout
    );
endinterface

// File: rtl/computation_sequencer.sv
// computation_sequencer: runs store then compute request phases,
// captures the 2x2 result and offers it with a valid/ready handshake.
module computation_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic                    clk,
    input logic                    rst,
    computation_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        STORE,
        COMP,
        HOLD
    } state_t;

    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_SA3    = 2'd1;
    localparam logic [1:0] M_SA2    = 2'd2;
    localparam logic [1:0] M_ILL    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             done_sel;
    logic             expired;
    logic             capture;
    logic             err_mode_d;
    logic             err_to_d;

    logic             act_st_q;
    logic             act_si_q;
    logic             act_s3_q;
    logic             act_s2_q;
    logic             busy_q;
    logic             valid_q;
    logic             em_q;
    logic             et_q;
    logic [7:0]       r11_q;
    logic [7:0]       r12_q;
    logic [7:0]       r21_q;
    logic [7:0]       r22_q;

    assign expired = (cnt_q == CNT_LAST);

    // Pick the done response of the engine chosen by the latched mode.
    always_comb begin
        done_sel = 1'b0;
        unique case (mode_q)
            M_SINGLE: done_sel = bus.done_single;
            M_SA3:    done_sel = bus.done_sa3;
            M_SA2:    done_sel = bus.done_sa2;
            default:  done_sel = 1'b0;
        endcase
    end

    // Next-state, watchdog and event decode; done beats expiry.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        err_mode_d = 1'b0;
        err_to_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mode == M_ILL) begin
                        err_mode_d = 1'b1;
                    end else begin
                        mode_d  = bus.mode;
                        cnt_d   = '0;
                        state_d = STORE;
                    end
                end
            end
            STORE: begin
                if (bus.done_store) begin
                    cnt_d   = '0;
                    state_d = COMP;
                end else if (expired) begin
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMP: begin
                if (done_sel) begin
                    cnt_d   = '0;
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (expired) begin
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched mode and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request levels and status flags, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_st_q <= 1'b0;
            act_si_q <= 1'b0;
            act_s3_q <= 1'b0;
            act_s2_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            em_q     <= 1'b0;
            et_q     <= 1'b0;
        end else begin
            act_st_q <= (state_d == STORE);
            act_si_q <= (state_d == COMP) && (mode_d == M_SINGLE);
            act_s3_q <= (state_d == COMP) && (mode_d == M_SA3);
            act_s2_q <= (state_d == COMP) && (mode_d == M_SA2);
            busy_q   <= (state_d != IDLE);
            valid_q  <= (state_d == HOLD);
            em_q     <= err_mode_d;
            et_q     <= err_to_d;
        end
    end

    // Result registers load only on the honoured compute done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r11_q <= 8'd0;
            r12_q <= 8'd0;
            r21_q <= 8'd0;
            r22_q <= 8'd0;
        end else if (capture) begin
            r11_q <= bus.c11;
            r12_q <= bus.c12;
            r21_q <= bus.c21;
            r22_q <= bus.c22;
        end
    end

    assign bus.active_store  = act_st_q;
    assign bus.active_single = act_si_q;
    assign bus.active_sa3    = act_s3_q;
    assign bus.active_sa2    = act_s2_q;
    assign bus.busy          = busy_q;
    assign bus.result_valid  = valid_q;
    assign bus.err_mode      = em_q;
    assign bus.err_timeout   = et_q;
    assign bus.r11           = r11_q;
    assign bus.r12           = r12_q;
    assign bus.r21           = r21_q;
    assign bus.r22           = r22_q;
endmodule

// File: doc/computation_sequencer.md
# computation_sequencer

Control-side counterpart of the computation datapath. It accepts a start command with a mode, drives the `active_store` then `active_single`/`active_sa3`/`active_sa2` request levels, and waits for the matching done responses. It captures the 2x2 result (`c11..c22`) in the cycle the selected engine reports done. It then presents the result downstream with a valid/ready handshake. A per-phase watchdog prevents hangs.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles any request level is held without a done response.
- `CNT_W`, default 7: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: command strobe, sampled only in IDLE.
- `mode` in 2: engine select, latched with `start`. 0 = single, 1 = sa3, 2 = sa2, 3 = illegal.
- `done_store`, `done_single`, `done_sa3`, `done_sa2` in 1 each: engine done responses.
- `c11`, `c12`, `c21`, `c22` in 8 each: result from the computation datapath.
- `result_ready` in 1: downstream accepts the result.
- `active_store`, `active_single`, `active_sa3`, `active_sa2` out 1 each: registered request levels. At most one is high in any cycle.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: result held on `r11..r22`.
- `r11`, `r12`, `r21`, `r22` out 8 each: captured result registers.
- `err_mode` out 1: one-cycle pulse when a start carries an illegal mode.
- `err_timeout` out 1: one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE, STORE, COMP, HOLD.
- IDLE:
  - `start`=1 with `mode`≤2: latch mode and go to STORE.
  - `start`=1 with `mode`=3: pulse `err_mode` next cycle and stay in IDLE.
  - `start`=0: stay in IDLE.
- STORE:
  - `active_store`=1.
  - `done_store`=1: go to COMP.
  - Other done inputs are ignored.
- COMP:
  - Only the `active_*` line selected by the latched mode is high.
  - Only the matching `done_*` is honoured; other done inputs are ignored.
  - On the matching done, load `r11..r22` from `c11..c22` in that same cycle, then go to HOLD.
- HOLD:
  - `result_valid`=1; `r*` stay stable.
  - `result_valid`=1 and `result_ready`=1: go to IDLE.
  - `start` is ignored throughout HOLD.
- Watchdog:
  - Counter clears on entry to STORE and on entry to COMP.
  - Counter increments every cycle spent in that state without the honoured done.
  - If the counter equals TIMEOUT_CYCLES-1 with no done in that cycle: go to IDLE, pulse `err_timeout`, leave `r*` unchanged, do not assert `result_valid`.
  - If done and expiry coincide, done wins.
- `start` while busy is dropped, not queued.
- `r*` retain their last captured value until the next capture.

## Timing
- Reset: all of the following go to 0 immediately and asynchronously, state = IDLE, counter = 0:
  - all `active_*`
  - `busy`
  - `result_valid`
  - `err_mode`, `err_timeout`
  - `r11..r22`
  - latched mode
- Reset asserted mid-operation aborts with no error pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start cycle: `start` sampled at edge T0.
  - T0+1: `active_store`=1, `busy`=1.
- Store phase: `done_store` sampled at edge Ts.
  - Ts+1: `active_store`=0 and selected `active_x`=1. No gap cycle and no overlap.
- Compute phase: `done_x` sampled at edge Tc.
  - Tc+1: `active_x`=0, `result_valid`=1, `r*` equal the `c*` values present during the cycle before Tc.
- Minimum latency from start to valid is 3 cycles, with `done_store` and `done_x` each returned one cycle after their request.
- Handshake completes at edge Th (valid and ready both high).
  - Th+1: `result_valid`=0, `busy`=0.
  - A new `start` is sampled no earlier than edge Th+1.
- Watchdog: a request level stays high at most TIMEOUT_CYCLES cycles.
  - `err_timeout` is high in the first cycle after the request drops, for exactly 1 cycle, together with `busy`=0.
- `err_mode` goes high the cycle after the illegal `start`, for 1 cycle. No `active_*` line asserts.

## Test plan
- **Mode 0 nominal:** start with mode=0; `done_store` 2 cycles after request; `done_single` 3 cycles after request with `c`=0x11,0x22,0x33,0x44; `result_ready`=1 → `r`=0x11,0x22,0x33,0x44, `result_valid` high 1 cycle, `active_single` high exactly 3 cycles.
- **Modes 1 and 2 with backpressure:** run modes 1 and 2; hold `result_ready`=0 for 5 cycles; drive stray `done_single` during COMP → only `active_sa3`/`active_sa2` assert; `r*` stable and `result_valid` high for 5+1 cycles; stray done ignored.
- **Illegal mode:** start with mode=3 → `err_mode` 1-cycle pulse; `busy` stays 0; no `active_*` asserts.
- **Watchdog:** TIMEOUT_CYCLES=8, never return `done_sa2` → `active_sa2` high for 8 cycles, then `err_timeout` pulse, IDLE, `r*` keep prior values. Second case: done arrives on the expiry cycle → normal capture and no error.
- **Reset and busy-start:** assert `rst` mid-COMP → all outputs 0 immediately, no error pulse. Drive `start` while in STORE → ignored; exactly one result is produced.
